// File: rtl/wt_cache_controller_if.sv
// CPU and memory-side signals for the write-through cache controller.
// The slave modport is the controller's view; master is the CPU/memory side.
interface wt_cache_controller_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic                  cpu_read_en;
    logic                  cpu_write_en;
    logic [DATA_WIDTH-1:0] cpu_write_data;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_read_data;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  cpu_address, cpu_read_en, cpu_write_en, cpu_write_data,
        input  mem_ready, mem_read_data,
        output cpu_ready, cpu_read_data,
        output mem_address, mem_read_en, mem_write_en, mem_write_data
    );

    modport master (
        output cpu_address, cpu_read_en, cpu_write_en, cpu_write_data,
        output mem_ready, mem_read_data,
        input  cpu_ready, cpu_read_data,
        input  mem_address, mem_read_en, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/wt_cache_controller.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache controller.
// Read hits are served locally; writes and read misses go to a ready-handshake memory.
module wt_cache_controller #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINES      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    wt_cache_controller_if.slave   bus,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);
    localparam int unsigned INDEX_W = $clog2(LINES);
    localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StMemWrite,
        StMemRead,
        StRefill,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_arr  [LINES];
    logic [DATA_WIDTH-1:0] data_arr [LINES];

    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic                  mem_read_en_q;
    logic                  mem_write_en_q;
    logic [DATA_WIDTH-1:0] mem_write_data_q;
    logic [DATA_WIDTH-1:0] cpu_read_data_q;
    logic [15:0]           hit_q;
    logic [15:0]           miss_q;

    logic [INDEX_W-1:0]    index_in;
    logic [TAG_W-1:0]      tag_in;
    logic                  hit;
    logic [INDEX_W-1:0]    refill_index;
    logic [TAG_W-1:0]      refill_tag;

    logic                  accept_write;
    logic                  read_hit;
    logic                  read_miss;
    logic                  write_done;
    logic                  read_done;
    logic                  refill;

    assign index_in = bus.cpu_address[INDEX_W-1:0];
    assign tag_in   = bus.cpu_address[ADDR_WIDTH-1:INDEX_W];
    assign hit      = valid_q[index_in] && (tag_arr[index_in] == tag_in);

    // mem_address_q holds the latched miss address until the refill completes.
    assign refill_index = mem_address_q[INDEX_W-1:0];
    assign refill_tag   = mem_address_q[ADDR_WIDTH-1:INDEX_W];

    always_comb begin
        state_d      = state_q;
        accept_write = 1'b0;
        read_hit     = 1'b0;
        read_miss    = 1'b0;
        write_done   = 1'b0;
        read_done    = 1'b0;
        refill       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Write takes priority when both enables are high.
                if (bus.cpu_write_en) begin
                    accept_write = 1'b1;
                    state_d      = StMemWrite;
                end else if (bus.cpu_read_en) begin
                    if (hit) begin
                        read_hit = 1'b1;
                        state_d  = StDone;
                    end else begin
                        read_miss = 1'b1;
                        state_d   = StMemRead;
                    end
                end
            end
            StMemWrite: begin
                if (bus.mem_ready) begin
                    write_done = 1'b1;
                    state_d    = StDone;
                end
            end
            StMemRead: begin
                if (bus.mem_ready) begin
                    read_done = 1'b1;
                    state_d   = StRefill;
                end
            end
            StRefill: begin
                refill  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            valid_q          <= '0;
            mem_address_q    <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_data_q <= '0;
            cpu_read_data_q  <= '0;
            hit_q            <= '0;
            miss_q           <= '0;
        end else begin
            state_q <= state_d;
            if (accept_write) begin
                mem_address_q    <= bus.cpu_address;
                mem_write_data_q <= bus.cpu_write_data;
                mem_write_en_q   <= 1'b1;
            end
            if (read_hit) begin
                cpu_read_data_q <= data_arr[index_in];
                if (hit_q != 16'hFFFF) begin
                    hit_q <= hit_q + 16'd1;
                end
            end
            if (read_miss) begin
                mem_address_q <= bus.cpu_address;
                mem_read_en_q <= 1'b1;
                if (miss_q != 16'hFFFF) begin
                    miss_q <= miss_q + 16'd1;
                end
            end
            if (write_done) begin
                mem_write_en_q <= 1'b0;
            end
            if (read_done) begin
                mem_read_en_q <= 1'b0;
            end
            if (refill) begin
                valid_q[refill_index] <= 1'b1;
                cpu_read_data_q       <= bus.mem_read_data;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (accept_write && hit) begin
            data_arr[index_in] <= bus.cpu_write_data;
        end
        if (refill) begin
            data_arr[refill_index] <= bus.mem_read_data;
            tag_arr[refill_index]  <= refill_tag;
        end
    end

    assign bus.cpu_ready      = (state_q == StDone);
    assign bus.cpu_read_data  = cpu_read_data_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_read_en    = mem_read_en_q;
    assign bus.mem_write_en   = mem_write_en_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign hit_count          = hit_q;
    assign miss_count         = miss_q;
endmodule

// File: doc/wt_cache_controller.md
Name: wt_cache_controller

Overview:
- Direct-mapped, one-word-per-line cache controller with a write-through, no-write-allocate policy.
- Sits between the CPU load/store port and the main memory stage. It serves read hits locally and forwards every write and every read miss to main memory.
- Main memory uses a fixed-latency ready handshake: the request is held until ready, and read data is valid the cycle after ready.

Parameters:
ADDR_WIDTH, 10, word address width; must match the memory address width.
DATA_WIDTH, 32, data word width.
LINES, 32, number of cache lines (power of two); INDEX_W = $clog2(LINES), TAG_W = ADDR_WIDTH - INDEX_W.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_address  input  ADDR_WIDTH  CPU word address
cpu_read_en  input  1  CPU read request; held until cpu_ready
cpu_write_en  input  1  CPU write request; held until cpu_ready
cpu_write_data  input  DATA_WIDTH  CPU store data
cpu_ready  output  1  one-cycle completion pulse
cpu_read_data  output  DATA_WIDTH  load result; valid while cpu_ready is high
mem_address  output  ADDR_WIDTH  memory address, registered
mem_read_en  output  1  memory read request, registered
mem_write_en  output  1  memory write request, registered
mem_write_data  output  DATA_WIDTH  memory write data, registered
mem_ready  input  1  memory ready strobe
mem_read_data  input  DATA_WIDTH  memory data; valid the cycle after mem_ready
hit_count  output  16  saturating read-hit counter
miss_count  output  16  saturating read-miss counter

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately.
  - All valid bits are cleared.
  - mem_read_en, mem_write_en and cpu_ready go to 0.
  - cpu_read_data, mem_address, mem_write_data, hit_count and miss_count go to 0.
  - Tag and data arrays are not reset.
  - Reset mid-transaction aborts it; no cpu_ready is issued and no cache line is updated.
- Address split: index = cpu_address[INDEX_W-1:0], tag = cpu_address[ADDR_WIDTH-1:INDEX_W]. Hit = valid[index] && tag_array[index] == tag.
- Request acceptance:
  - A request is accepted only in IDLE.
  - cpu_address and cpu_write_data are latched on acceptance, so later changes are ignored until DONE.
  - If both enables are high, the request is treated as a write.
- FSM states: IDLE, MEM_WRITE, MEM_READ, REFILL, DONE.
  - IDLE, write request: update the line if it hits (data only; valid and tag are unchanged). On a miss, do not allocate. Load mem_address/mem_write_data, set mem_write_en, go to MEM_WRITE.
  - IDLE, read hit: register the line data into cpu_read_data, increment hit_count, go to DONE.
  - IDLE, read miss: increment miss_count, load mem_address, set mem_read_en, go to MEM_READ.
  - MEM_WRITE: hold mem_write_en. When mem_ready is sampled high, clear mem_write_en and go to DONE.
  - MEM_READ: hold mem_read_en. When mem_ready is sampled high, clear mem_read_en and go to REFILL.
  - REFILL: capture mem_read_data into data_array[index], set tag_array[index] and valid[index], load cpu_read_data, go to DONE.
  - DONE: cpu_ready = 1 for this cycle only. CPU inputs are ignored. Next state is IDLE.
- Memory enables deassert on the cycle after mem_ready, so the memory stage completes exactly one access per transaction.
- Latency, from the accept edge (cycle 0) to cpu_ready, against a memory whose ready arrives in the 5th enable cycle:
  - Read hit: cycle 1.
  - Write (hit or miss): cycle 6.
  - Read miss: cycle 7.
  - Back-to-back throughput is at best one request per 2 cycles.
- Counters saturate at 16'hFFFF. Writes do not affect the counters.
- mem_ready seen while in IDLE, DONE or REFILL is ignored.

Test Plan:
1. Reset, then read address 0x005 (memory holds 0 after its reset) -> mem_read_en high for 5 cycles; cpu_ready at cycle 7 with cpu_read_data = 0; miss_count = 1, hit_count = 0.
2. Write 0xDEADBEEF to 0x045 (index 5, line invalid, no allocate), then read 0x045 -> the write completes at cycle 6 and memory holds the value; the read misses, returns 0xDEADBEEF at cycle 7 and fills the line; a second read hits with cpu_ready at cycle 1 and hit_count = 1.
3. With 0x045 cached, write 0x12345678 to 0x045 -> the cache line and memory both update; a following read hits and returns 0x12345678 at cycle 1 with no mem_read_en.
4. Aliasing: with 0x045 cached, read 0x065 (same index, different tag) -> miss, the line is replaced; a read of 0x045 then misses again; miss_count increments each time.
5. Assert both enables together with address 0x010 and data 0xA5A5A5A5 -> treated as a write: mem_write_en is asserted, mem_read_en stays low, cpu_ready at cycle 6.
6. Assert reset during MEM_READ at cycle 3 -> mem_read_en drops immediately with no clock edge; no cpu_ready; after release, a read of the same address misses again.
